// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the sequence stimulus shifter and detector.
// State typedef, default widths and pattern-length normalisation.
package seq_det_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } seq_state_t;

    localparam int SEQ_WIDTH = 16;
    localparam int SEQ_LEN_W = 5;

    // 0 selects the full width; anything above the width is clamped to it.
    function automatic int unsigned seq_norm_len(input int unsigned len, input int unsigned width);
        if (len == 0 || len > width)
            return width;
        return len;
    endfunction

endpackage

// File: rtl/seq_bit_counter.sv
// Loadable down-counter tracking bits left and bits emitted in a pass.
// last is high while the bit currently on the line is the final one.
module seq_bit_counter
    import seq_det_pkg::*;
#(
    parameter int LEN_W = SEQ_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] remaining,
    output logic [LEN_W-1:0] bit_idx,
    output logic             last
);

    // A load already accounts for the first bit being presented.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            remaining <= '0;
            bit_idx   <= '0;
        end else if (load) begin
            remaining <= len - LEN_W'(1);
            bit_idx   <= LEN_W'(1);
        end else if (step && remaining != '0) begin
            remaining <= remaining - LEN_W'(1);
            bit_idx   <= bit_idx + LEN_W'(1);
        end
    end

    assign last = (remaining == '0);

endmodule

// File: rtl/seq_stimulus_shifter.sv
// Serial MSB-first pattern source feeding the sequence detector X input.
// Define SEQ_SHIFT_LOOP_EN to add the loop port for gapless pattern replay.
module seq_stimulus_shifter
    import seq_det_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int LEN_W = SEQ_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic             abort,
`ifdef SEQ_SHIFT_LOOP_EN
    input  logic             loop,
`endif
    output logic             X,
    output logic             busy,
    output logic [LEN_W-1:0] bit_idx,
    output logic             done
);

    seq_state_t       state, next_state;
    logic [WIDTH-1:0] shreg, patreg, aligned;
    logic [LEN_W-1:0] len_n, len_reg, ctr_len, remaining;
    logic             last, accept, reload, ending, step, loop_en;

`ifdef SEQ_SHIFT_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    assign len_n   = LEN_W'(seq_norm_len(32'(load_len), WIDTH));
    assign aligned = load_data << (WIDTH - int'(len_n));

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        reload     = 1'b0;
        ending     = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    accept     = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    ending     = 1'b1;
                    next_state = IDLE;
                end else if (last) begin
                    if (loop_en) begin
                        reload = 1'b1;
                    end else begin
                        ending     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign step    = (state == SHIFT) && !ending && !reload;
    assign ctr_len = accept ? len_n : len_reg;

    seq_bit_counter #(.LEN_W(LEN_W)) u_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (ending),
        .load      (accept || reload),
        .step      (step),
        .len       (ctr_len),
        .remaining (remaining),
        .bit_idx   (bit_idx),
        .last      (last)
    );

    // X is registered: the first bit is placed on X by the accepting edge,
    // so shreg keeps only the bits still to come.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            X       <= 1'b0;
            shreg   <= '0;
            patreg  <= '0;
            len_reg <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                X       <= aligned[WIDTH-1];
                shreg   <= aligned << 1;
                patreg  <= aligned;
                len_reg <= len_n;
            end else if (reload) begin
                X     <= patreg[WIDTH-1];
                shreg <= patreg << 1;
            end else if (ending) begin
                X     <= 1'b0;
                shreg <= '0;
            end else if (state == SHIFT) begin
                X     <= shreg[WIDTH-1];
                shreg <= shreg << 1;
            end
        end
    end

    assign busy       = (state == SHIFT);
    assign load_ready = (state == IDLE);
    assign done       = busy && last;

endmodule

// File: tb/tb_seq_stimulus_shifter.sv
// Self-checking bench for seq_stimulus_shifter against a bit-stream model.
// Exercises the loop feature when SEQ_SHIFT_LOOP_EN is defined.
module tb_seq_stimulus_shifter;

    localparam int W  = 16;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [W-1:0]  load_data;
    logic [LW-1:0] load_len;
    logic          abort;
    logic          X;
    logic          busy;
    logic [LW-1:0] bit_idx;
    logic          done;
`ifdef SEQ_SHIFT_LOOP_EN
    logic          loop;
`endif

    int       compared   = 0;
    int       mismatched = 0;
    int       z_count;
    logic [5:0] hist;
    logic [8:0] got, exp;

    always #5 clk = ~clk;

    seq_stimulus_shifter #(.WIDTH(W), .LEN_W(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .abort      (abort),
`ifdef SEQ_SHIFT_LOOP_EN
        .loop       (loop),
`endif
        .X          (X),
        .busy       (busy),
        .bit_idx    (bit_idx),
        .done       (done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned ref_len(input int unsigned len);
        return (len == 0 || len > W) ? W : len;
    endfunction

    // Offers one pattern, then follows the whole pass; ends in the idle cycle.
    task automatic drive_pass(input logic [W-1:0] data, input logic [LW-1:0] len,
                              input bit hold, input string name);
        int unsigned L;
        L = ref_len(len);
        load_data  = data;
        load_len   = len;
        load_valid = 1'b1;
        tick();
        if (!hold) load_valid = 1'b0;
        hist = '0;
        for (int unsigned k = 0; k < L; k++) begin
            exp = {data[L-1-k], 1'b1, (k == L-1), 1'b0, LW'(k+1)};
            got = {X, busy, done, load_ready, bit_idx};
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL %s bit %0d: {X,busy,done,rdy,idx} got %b want %b", name, k, got, exp);
            end
            hist = {hist[4:0], X};
            if (k >= 5 && hist == 6'b101101) z_count++;
            tick();
        end
        exp = {1'b0, 1'b0, 1'b0, 1'b1, LW'(0)};
        got = {X, busy, done, load_ready, bit_idx};
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s idle after pass: got %b want %b", name, got, exp);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; load_valid = 1'b0; abort = 1'b0; load_data = '0; load_len = '0;
`ifdef SEQ_SHIFT_LOOP_EN
        loop = 1'b0;
`endif
        tick(); tick();
        reset = 1'b0;
        tick();
        exp = {1'b0, 1'b0, 1'b0, 1'b1, LW'(0)};
        got = {X, busy, done, load_ready, bit_idx};
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL reset_state: got %b want %b", got, exp);
        end
    endtask

    task automatic test_basic_and_overlap;
        z_count = 0;
        drive_pass(16'h002D, 5'd6, 1'b0, "basic");
        compared++;
        if (z_count !== 1) begin
            mismatched++;
            $display("FAIL basic_detect: hits %0d want 1", z_count);
        end
        z_count = 0;
        drive_pass(16'h016D, 5'd9, 1'b0, "overlap");
        compared++;
        if (z_count !== 2) begin
            mismatched++;
            $display("FAIL overlap_detect: hits %0d want 2", z_count);
        end
    endtask

    task automatic test_len_edges;
        drive_pass(16'h8001, 5'd0, 1'b0, "len0");
        drive_pass(16'h8001, 5'd20, 1'b0, "len20");
        drive_pass(16'hFFFF, 5'd1, 1'b0, "len1");
        drive_pass(16'hA5C3, 5'd16, 1'b0, "len16");
    endtask

    task automatic test_random;
        for (int i = 0; i < 25; i++)
            drive_pass(W'($urandom), LW'($urandom_range(0, 31)), 1'b0, "random");
    endtask

    task automatic test_back_to_back;
        load_data = 16'h002D;
        drive_pass(16'h002D, 5'd6, 1'b1, "b2b_first");
        drive_pass(16'h0005, 5'd3, 1'b0, "b2b_second");
    endtask

    task automatic test_abort;
        load_data = 16'h002D; load_len = 5'd6; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp = {load_data[5-k], 1'b1, 1'b0, 1'b0, LW'(k+1)};
            got = {X, busy, done, load_ready, bit_idx};
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL abort_prefix bit %0d: got %b want %b", k, got, exp);
            end
            if (k == 2) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        exp = {1'b0, 1'b0, 1'b0, 1'b1, LW'(0)};
        got = {X, busy, done, load_ready, bit_idx};
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL abort_mid: got %b want %b", got, exp);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        got = {X, busy, done, load_ready, bit_idx};
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL abort_idle: got %b want %b", got, exp);
        end
        abort = 1'b1; load_valid = 1'b1;
        tick();
        abort = 1'b0; load_valid = 1'b0;
        exp = {1'b1, 1'b1, 1'b0, 1'b0, LW'(1)};
        got = {X, busy, done, load_ready, bit_idx};
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL abort_with_load: got %b want %b", got, exp);
        end
        for (int k = 0; k < 5; k++) tick();
    endtask

    task automatic test_reset_mid;
        load_data = 16'h002D; load_len = 5'd6; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp = {1'b0, 1'b0, 1'b0, 1'b1, LW'(0)};
        got = {X, busy, done, load_ready, bit_idx};
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL reset_mid: got %b want %b", got, exp);
        end
        drive_pass(16'h0005, 5'd3, 1'b0, "after_reset");
    endtask

`ifdef SEQ_SHIFT_LOOP_EN
    task automatic test_loop;
        logic [2:0] pat;
        pat = 3'b101;
        load_data = 16'h0005; load_len = 5'd3; load_valid = 1'b1; loop = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            exp = {pat[2 - (k % 3)], 1'b1, (k % 3 == 2), 1'b0, LW'(k % 3 + 1)};
            got = {X, busy, done, load_ready, bit_idx};
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL loop bit %0d: got %b want %b", k, got, exp);
            end
            if (k == 5) loop = 1'b0;
            tick();
        end
        exp = {1'b0, 1'b0, 1'b0, 1'b1, LW'(0)};
        got = {X, busy, done, load_ready, bit_idx};
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL loop_end: got %b want %b", got, exp);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_and_overlap();
        test_len_edges();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
`ifdef SEQ_SHIFT_LOOP_EN
        test_loop();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
